// File: rtl/note_rom_loader.sv
// rtl/note_rom_loader.sv - assembles a byte stream into 16-bit note words in RAM; optional NOTE_ROM_LOADER_CHECKSUM_EN
module note_rom_loader #(
    parameter int DEPTH  = 17,
    parameter int ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [7:0]        i_byte,
    input  logic              i_byte_valid,
    input  logic              i_byte_last,
    output logic              o_byte_ready,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [15:0]       o_rd_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W:0]   o_word_count,
    output logic [7:0]        o_checksum
);

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic [7:0]        low_q, low_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic [15:0]       rd_data_q, rd_data_d;
    logic              wr_en;
    logic [15:0]       wr_data;
    logic              accept;
    logic              start_clr;

    logic [15:0] mem [DEPTH];

    assign accept    = i_byte_valid && ready_q;
    // i_start is ignored only in DONE; in LO/HI it restarts and drops a same-edge byte
    assign start_clr = i_start && (state_q != S_DONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            wr_addr_q    <= '0;
            count_q      <= '0;
            word_count_q <= '0;
            low_q        <= '0;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            count_q      <= count_d;
            word_count_q <= word_count_d;
            low_q        <= low_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            rd_data_q    <= rd_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        count_d   = count_q;
        low_d     = low_q;
        wr_en     = 1'b0;
        wr_data   = 16'h0000;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d   = S_LO;
                    wr_addr_d = '0;
                    count_d   = '0;
                end
            end
            S_LO: begin
                if (i_start) begin
                    state_d   = S_LO;
                    wr_addr_d = '0;
                    count_d   = '0;
                end else if (accept) begin
                    low_d = i_byte;
                    if (i_byte_last) begin
                        wr_en   = 1'b1;
                        wr_data = {8'h00, i_byte};
                        count_d = count_q + 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_HI;
                    end
                end
            end
            S_HI: begin
                if (i_start) begin
                    state_d   = S_LO;
                    wr_addr_d = '0;
                    count_d   = '0;
                end else if (accept) begin
                    wr_en   = 1'b1;
                    wr_data = {i_byte, low_q};
                    count_d = count_q + 1'b1;
                    if (i_byte_last || wr_addr_q == LAST_ADDR) begin
                        state_d = S_DONE;
                    end else begin
                        wr_addr_d = wr_addr_q + 1'b1;
                        state_d   = S_LO;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they come straight from flops
    always_comb begin
        ready_d      = (state_d == S_LO) || (state_d == S_HI);
        done_d       = (state_d == S_DONE);
        word_count_d = (state_d == S_DONE) ? count_d : word_count_q;
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr_q] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = 16'h0000;
        if ({1'b0, i_rd_addr} < DEPTH_W) begin
            rd_data_d = mem[i_rd_addr];
        end
    end

    assign o_byte_ready = ready_q;
    assign o_busy       = ready_q;
    assign o_done       = done_q;
    assign o_word_count = word_count_q;
    assign o_rd_data    = rd_data_q;

`ifdef NOTE_ROM_LOADER_CHECKSUM_EN
    logic [7:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (start_clr) begin
            checksum_d = 8'h00;
        end else if (accept) begin
            checksum_d = checksum_q ^ i_byte;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            checksum_q <= 8'h00;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign o_checksum = checksum_q;
`else
    assign o_checksum = 8'h00;
`endif

endmodule

// File: tb/tb_note_rom_loader.sv
// tb/tb_note_rom_loader.sv - randomized self-checking bench for note_rom_loader against a word-level model
module tb_note_rom_loader;

    localparam int DEPTH  = 17;
    localparam int ADDR_W = 5;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_start = 1'b0;
    logic [7:0]        i_byte = 8'h00;
    logic              i_byte_valid = 1'b0;
    logic              i_byte_last = 1'b0;
    logic              o_byte_ready;
    logic [ADDR_W-1:0] i_rd_addr = '0;
    logic [15:0]       o_rd_data;
    logic              o_busy;
    logic              o_done;
    logic [ADDR_W:0]   o_word_count;
    logic [7:0]        o_checksum;

    note_rom_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .i_byte(i_byte), .i_byte_valid(i_byte_valid), .i_byte_last(i_byte_last),
        .o_byte_ready(o_byte_ready), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
        .o_busy(o_busy), .o_done(o_done), .o_word_count(o_word_count), .o_checksum(o_checksum)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int done_cnt = 0;

    always @(negedge i_clk) if (o_done === 1'b1) done_cnt++;

    // Model: bytes accepted since the last start, the running XOR, and the RAM image
    logic [7:0]  acc[$];
    logic [7:0]  ck_m;
    logic [15:0] mem_m [DEPTH];
    bit          mem_v [DEPTH];

    function automatic logic [7:0] ck_exp();
`ifdef NOTE_ROM_LOADER_CHECKSUM_EN
        return ck_m;
`else
        return 8'h00;
`endif
    endfunction

    task automatic model_commit(input bit complete_only, output int words);
        int n;
        n = acc.size();
        words = 0;
        for (int w = 0; w < DEPTH; w++) begin
            if (2 * w + 1 < n) mem_m[w] = {acc[2 * w + 1], acc[2 * w]};
            else if (2 * w < n && !complete_only) mem_m[w] = {8'h00, acc[2 * w]};
            else break;
            mem_v[w] = 1'b1;
            words++;
        end
    endtask

    task automatic start_pulse();
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        acc.delete();
        ck_m = 8'h00;
    endtask

    task automatic push(input logic [7:0] b, input bit last, output bit ok);
        i_byte = b; i_byte_valid = 1'b1; i_byte_last = last; ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge i_clk);
            ok = o_byte_ready;
            @(posedge i_clk); #1;
        end
        i_byte_valid = 1'b0; i_byte_last = $urandom_range(0, 1);
        if (ok) begin
            acc.push_back(b);
            ck_m = ck_m ^ b;
        end
        repeat ($urandom_range(0, 2)) begin @(posedge i_clk); #1; end
        i_byte_last = 1'b0;
    endtask

    task automatic rd(input int a, output logic [15:0] d);
        i_rd_addr = 5'(a);
        @(posedge i_clk); #1;
        d = o_rd_data;
    endtask

    task automatic wait_done(input int base);
        for (int t = 0; t < 10; t++) begin
            if (done_cnt != base) break;
            @(posedge i_clk); #1;
        end
        n_cmp++;
        if (done_cnt == base) begin
            n_fail++;
            $display("FAIL done_timeout: no o_done pulse within 10 cycles");
        end
        repeat (3) begin @(posedge i_clk); #1; end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (2) begin @(posedge i_clk); #1; end
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        n_cmp++; if (o_byte_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", o_byte_ready); end
        n_cmp++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", o_done); end
        n_cmp++; if (o_word_count !== 6'd0) begin n_fail++; $display("FAIL reset_wc: got %0d want 0", o_word_count); end
        n_cmp++; if (o_rd_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rd: got %h want 0000", o_rd_data); end
        n_cmp++; if (o_checksum !== 8'h00) begin n_fail++; $display("FAIL reset_ck: got %h want 00", o_checksum); end
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
    endtask

    task automatic test_full_pattern();
        int base, words, got_acc;
        bit ok;
        logic [7:0] lo;
        logic [15:0] d;
        base = done_cnt;
        start_pulse();
        n_cmp++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL full_busy: got %b want 1", o_busy); end
        for (int k = 0; k < DEPTH; k++) begin
            lo = 8'(k + 1);
            push(lo, 1'b0, ok);
            push({lo[3:0], lo[7:4]}, k == DEPTH - 1, ok);
        end
        wait_done(base);
        got_acc = acc.size();
        model_commit(1'b0, words);
        n_cmp++; if (got_acc != 34) begin n_fail++; $display("FAIL full_accepted: got %0d want 34", got_acc); end
        n_cmp++; if (done_cnt - base != 1) begin n_fail++; $display("FAIL full_done_cnt: got %0d want 1", done_cnt - base); end
        n_cmp++; if (o_word_count !== 6'd17) begin n_fail++; $display("FAIL full_wc: got %0d want 17", o_word_count); end
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_end: got %b want 0", o_busy); end
        rd(0, d);
        n_cmp++; if (d !== 16'h1001) begin n_fail++; $display("FAIL full_addr0: got %h want 1001", d); end
        rd(16, d);
        n_cmp++; if (d !== 16'h1111) begin n_fail++; $display("FAIL full_addr16: got %h want 1111", d); end
        for (int a = 0; a < DEPTH; a++) begin
            rd(a, d);
            n_cmp++; if (d !== mem_m[a]) begin n_fail++; $display("FAIL full_ram[%0d]: got %h want %h", a, d, mem_m[a]); end
        end
        n_cmp++; if (o_checksum !== ck_exp()) begin n_fail++; $display("FAIL full_ck: got %h want %h", o_checksum, ck_exp()); end
    endtask

    task automatic test_short();
        int base, words;
        bit ok;
        logic [15:0] d;
        base = done_cnt;
        start_pulse();
        push(8'hAA, 1'b0, ok);
        push(8'hBB, 1'b0, ok);
        push(8'hCC, 1'b1, ok);
        wait_done(base);
        model_commit(1'b0, words);
        n_cmp++; if (o_word_count !== 6'd2) begin n_fail++; $display("FAIL short_wc: got %0d want 2", o_word_count); end
        n_cmp++; if (done_cnt - base != 1) begin n_fail++; $display("FAIL short_done_cnt: got %0d want 1", done_cnt - base); end
        rd(0, d);
        n_cmp++; if (d !== 16'hBBAA) begin n_fail++; $display("FAIL short_addr0: got %h want BBAA", d); end
        rd(1, d);
        n_cmp++; if (d !== 16'h00CC) begin n_fail++; $display("FAIL short_addr1: got %h want 00CC", d); end
        rd(2, d);
        n_cmp++; if (d !== mem_m[2]) begin n_fail++; $display("FAIL short_addr2_kept: got %h want %h", d, mem_m[2]); end
        n_cmp++; if (o_checksum !== ck_exp()) begin n_fail++; $display("FAIL short_ck: got %h want %h", o_checksum, ck_exp()); end
    endtask

    task automatic test_overflow();
        int base, words, got_acc;
        bit ok;
        logic [15:0] d;
        base = done_cnt;
        start_pulse();
        for (int i = 0; i < 40; i++) push(8'($urandom), 1'b0, ok);
        wait_done(base);
        got_acc = acc.size();
        model_commit(1'b0, words);
        n_cmp++; if (got_acc != 34) begin n_fail++; $display("FAIL ovf_accepted: got %0d want 34", got_acc); end
        n_cmp++; if (o_byte_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready: got %b want 0", o_byte_ready); end
        n_cmp++; if (o_word_count !== 6'd17) begin n_fail++; $display("FAIL ovf_wc: got %0d want 17", o_word_count); end
        n_cmp++; if (done_cnt - base != 1) begin n_fail++; $display("FAIL ovf_done_cnt: got %0d want 1", done_cnt - base); end
        for (int a = 0; a < DEPTH; a++) begin
            rd(a, d);
            n_cmp++; if (d !== mem_m[a]) begin n_fail++; $display("FAIL ovf_ram[%0d]: got %h want %h", a, d, mem_m[a]); end
        end
        n_cmp++; if (o_checksum !== ck_exp()) begin n_fail++; $display("FAIL ovf_ck: got %h want %h", o_checksum, ck_exp()); end
    endtask

    task automatic test_restart();
        int base, words;
        bit ok;
        logic [15:0] d;
        base = done_cnt;
        start_pulse();
        for (int i = 0; i < 5; i++) push(8'($urandom), 1'b0, ok);
        model_commit(1'b1, words);
        i_start = 1'b1; i_byte = 8'h77; i_byte_valid = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_byte_valid = 1'b0;
        acc.delete();
        ck_m = 8'h00;
        push(8'h34, 1'b0, ok);
        push(8'h12, 1'b1, ok);
        wait_done(base);
        model_commit(1'b0, words);
        n_cmp++; if (done_cnt - base != 1) begin n_fail++; $display("FAIL rst_done_cnt: got %0d want 1", done_cnt - base); end
        n_cmp++; if (o_word_count !== 6'd1) begin n_fail++; $display("FAIL rst_wc: got %0d want 1", o_word_count); end
        rd(0, d);
        n_cmp++; if (d !== 16'h1234) begin n_fail++; $display("FAIL rst_addr0: got %h want 1234", d); end
        rd(1, d);
        n_cmp++; if (d !== mem_m[1]) begin n_fail++; $display("FAIL rst_addr1_kept: got %h want %h", d, mem_m[1]); end
        n_cmp++; if (o_checksum !== ck_exp()) begin n_fail++; $display("FAIL rst_ck: got %h want %h", o_checksum, ck_exp()); end
    endtask

    task automatic test_random();
        int base, words, n;
        bit ok;
        logic [15:0] d;
        for (int it = 0; it < 4; it++) begin
            base = done_cnt;
            n = $urandom_range(1, 34);
            start_pulse();
            for (int i = 0; i < n; i++) push(8'($urandom), i == n - 1, ok);
            wait_done(base);
            model_commit(1'b0, words);
            n_cmp++; if (o_word_count !== 6'((n + 1) / 2)) begin n_fail++; $display("FAIL rnd_wc: got %0d want %0d", o_word_count, (n + 1) / 2); end
            n_cmp++; if (done_cnt - base != 1) begin n_fail++; $display("FAIL rnd_done_cnt: got %0d want 1", done_cnt - base); end
            for (int a = 0; a < DEPTH; a++) begin
                rd(a, d);
                n_cmp++; if (d !== mem_m[a]) begin n_fail++; $display("FAIL rnd_ram[%0d]: got %h want %h", a, d, mem_m[a]); end
            end
            n_cmp++; if (o_checksum !== ck_exp()) begin n_fail++; $display("FAIL rnd_ck: got %h want %h", o_checksum, ck_exp()); end
        end
    endtask

    task automatic test_checksum();
        int base;
        bit ok;
        logic [7:0] mid;
        base = done_cnt;
        start_pulse();
        push(8'h0F, 1'b0, ok);
        push(8'hF0, 1'b0, ok);
`ifdef NOTE_ROM_LOADER_CHECKSUM_EN
        mid = 8'hFF;
`else
        mid = 8'h00;
`endif
        n_cmp++; if (o_checksum !== mid) begin n_fail++; $display("FAIL ck_mid: got %h want %h", o_checksum, mid); end
        push(8'hFF, 1'b1, ok);
        wait_done(base);
        n_cmp++; if (o_checksum !== 8'h00) begin n_fail++; $display("FAIL ck_final: got %h want 00", o_checksum); end
    endtask

    task automatic test_reset_midload();
        int words;
        bit ok;
        logic [15:0] d;
        start_pulse();
        for (int i = 0; i < 3; i++) push(8'($urandom), 1'b0, ok);
        model_commit(1'b1, words);
        #2 i_rst_n = 1'b0;
        #1;
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", o_busy); end
        n_cmp++; if (o_byte_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 0", o_byte_ready); end
        i_rd_addr = 5'd20;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        rd(20, d);
        n_cmp++; if (d !== 16'h0000) begin n_fail++; $display("FAIL rd_addr20: got %h want 0000", d); end
        rd(17, d);
        n_cmp++; if (d !== 16'h0000) begin n_fail++; $display("FAIL rd_addr17: got %h want 0000", d); end
        rd(0, d);
        n_cmp++; if (d !== mem_m[0]) begin n_fail++; $display("FAIL mid_rst_kept0: got %h want %h", d, mem_m[0]); end
        n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_idle: got %b want 0", o_busy); end
    endtask

    initial begin
        ck_m = 8'h00;
        for (int a = 0; a < DEPTH; a++) begin mem_m[a] = 16'h0000; mem_v[a] = 1'b0; end
        test_reset();
        test_full_pattern();
        test_short();
        test_overflow();
        test_restart();
        test_random();
        test_checksum();
        test_reset_midload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/note_rom_loader.md
Name: note_rom_loader

Overview:
- Write-side counterpart to the note sequencer's ROM read port.
- Accepts a byte stream with a valid/ready handshake and assembles 16-bit note words, low byte first.
- Writes the words into internal RAM of DEPTH entries and serves the sequencer through a synchronous read port with 1-cycle latency.
- Raises o_busy while loading so the sequencer is held in reset during a pattern update.

Parameters:
- DEPTH, 17, number of 16-bit note words stored.
- ADDR_W, 5, address width; DEPTH must be <= 2**ADDR_W.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  single-cycle pulse; begins a load at word address 0.
- i_byte  in  8  stream data byte.
- i_byte_valid  in  1  i_byte is valid this cycle.
- i_byte_last  in  1  qualifies the final byte of the pattern; valid only with i_byte_valid.
- o_byte_ready  out  1  loader accepts a byte this cycle.
- i_rd_addr  in  ADDR_W  sequencer read address.
- o_rd_data  out  16  read data, 1 cycle after i_rd_addr.
- o_busy  out  1  load in progress.
- o_done  out  1  single-cycle pulse when a load completes.
- o_word_count  out  ADDR_W+1  number of words written by the last load.
- o_checksum  out  8  XOR of all accepted bytes (optional feature).

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; o_byte_ready=0, o_busy=0, o_done=0, o_word_count=0, o_rd_data=0, o_checksum=0.
  - RAM contents are not reset.
- Handshake: a byte is accepted on a clock edge where i_byte_valid && o_byte_ready. o_byte_ready is registered and equals 1 exactly in states LO and HI.
- States:
  - IDLE:
    - i_start -> LO; wr_addr=0; count=0; checksum cleared.
    - o_busy=1 from the cycle after i_start.
  - LO:
    - On accept: latch the low byte.
    - Not last -> HI.
    - Last -> write {8'h00, byte} at wr_addr, then -> DONE.
  - HI:
    - On accept: write {byte, low} at wr_addr and increment count.
    - If last, or wr_addr==DEPTH-1 -> DONE.
    - Else wr_addr+1, -> LO.
  - DONE (one cycle):
    - o_done=1; o_word_count=count; o_busy=0.
    - -> IDLE.
- Full: after the DEPTH-th word is written, the loader goes to DONE regardless of i_byte_last. No bytes are accepted beyond DEPTH words and nothing wraps.
- i_start while in LO or HI:
  - Restart: wr_addr=0, count=0, state LO.
  - A byte accepted on the same edge is dropped.
  - Words already written stay in RAM; o_done does not fire for the aborted load.
- i_start in DONE: ignored.
- i_byte_last without i_byte_valid: ignored.
- Read port:
  - o_rd_data <= RAM[i_rd_addr] on every clock, independent of state.
  - i_rd_addr >= DEPTH returns 16'h0000.
  - Read and write to the same address on the same edge returns the old data.
- Reset during a load: immediate return to IDLE with o_busy=0; partially written words remain.

Optional Feature:
- NOTE_ROM_LOADER_CHECKSUM_EN defined:
  - o_checksum is the XOR of every accepted byte since the last i_start.
  - It updates on each accept and holds after DONE until the next i_start.
- Not defined: o_checksum is tied to 8'h00 and no checksum logic is synthesised.

Test Plan:
- Reset then i_start. Stream 34 bytes, lo/hi pairs 0x01,0x10 ... with last on byte 34 -> o_done pulses once, o_word_count=17, reading addr 0 gives 16'h1001 one cycle later, addr 16 holds the final pair.
- Load 3 bytes AA,BB,CC with last on CC -> addr0=16'hBBAA, addr1=16'h00CC, o_word_count=2.
- Stream 40 bytes with no last -> DONE after byte 34, o_byte_ready=0 from then on, o_word_count=17.
- i_start pulse after 5 accepted bytes, then 2 bytes 0x34,0x12 with last -> addr0=16'h1234, o_word_count=1, exactly one o_done.
- Assert i_rst_n=0 mid-load -> o_busy and o_byte_ready drop asynchronously. i_rd_addr=20 -> o_rd_data=0.
- With the checksum macro, bytes 0x0F,0xF0,0xFF (last) -> o_checksum=8'h00. Without it, o_checksum=8'h00 always.
